// File: rtl/pcount_pkg.sv
// Shared types and helpers for the pulse-count digit link transmitter.
package pcount_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } tx_state_t;

    // Largest value representable in ndig decimal digits (10**ndig - 1).
    function automatic int max_count(input int ndig);
        int v;
        v = 1;
        for (int i = 0; i < ndig; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/pcount_digit_tx_bcd_add3.sv
// One shift-and-add-3 correction cell: bumps a BCD digit by 3 when it is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_add3
    import pcount_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? bcd_digit_t'(i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/pcount_digit_tx.sv
// Pulse-count digit transmitter: latches a saturated binary count, converts it to BCD
// with one shift-and-add-3 step per clock, then streams the digits MSD first with a
// one-cycle strobe per digit and a done pulse after the last one.
module pcount_digit_tx
    import pcount_pkg::*;
#(
    parameter int CNT_W = 10,
    parameter int NDIG  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             ready,
    output logic [3:0]       q_out,
    output logic             iden,
    output logic             done
);

    localparam int                 BCD_W      = NDIG * 4;
    localparam int                 STEP_W     = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0]   MAX_C      = CNT_W'(max_count(NDIG));
    localparam logic [STEP_W-1:0]  STEPS_CONV = STEP_W'(CNT_W);
    localparam logic [STEP_W-1:0]  STEPS_SEND = STEP_W'(NDIG);
    localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);

    tx_state_t           r_state;
    logic [BCD_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_bin;
    logic [STEP_W-1:0]   r_step;
    logic [3:0]          r_q;
    logic                r_iden;
    logic                r_done;

    logic [BCD_W-1:0]        w_bcd_adj;
    logic [BCD_W+CNT_W-1:0]  w_shift;
    logic [CNT_W-1:0]        w_count_sat;

    // Per-digit add-3 correction; digits are independent, no carry between them.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_bcd[gi*4 +: 4]),
                .o_digit (w_bcd_adj[gi*4 +: 4])
            );
        end
    endgenerate

    assign w_shift     = {w_bcd_adj, r_bin} << 1;
    assign w_count_sat = (count > MAX_C) ? MAX_C : count;

    // DONE doubles as an idle cycle so back-to-back frames need no gap.
    assign ready = (r_state == IDLE) || (r_state == DONE);
    assign q_out = r_q;
    assign iden  = r_iden;
    assign done  = r_done;

    // Frame sequencer: accept, convert CNT_W steps, emit NDIG digits, pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_step  <= '0;
            r_q     <= 4'h0;
            r_iden  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    r_iden <= 1'b0;
                    r_q    <= 4'h0;
                    if (start) begin
                        r_bin   <= w_count_sat;
                        r_bcd   <= '0;
                        r_step  <= STEPS_CONV;
                        r_state <= CONV;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CONV: begin
                    r_bcd <= w_shift[BCD_W+CNT_W-1:CNT_W];
                    r_bin <= w_shift[CNT_W-1:0];
                    if (r_step == STEP_ONE) begin
                        r_step  <= STEPS_SEND;
                        r_state <= SEND;
                    end else begin
                        r_step <= r_step - STEP_ONE;
                    end
                end
                SEND: begin
                    if (r_step != '0) begin
                        // Most-significant digit sits at the top; shift it out.
                        r_iden <= 1'b1;
                        r_q    <= r_bcd[BCD_W-1 -: 4];
                        r_bcd  <= {r_bcd[BCD_W-5:0], 4'h0};
                        r_step <= r_step - STEP_ONE;
                    end else begin
                        r_iden  <= 1'b0;
                        r_q     <= 4'h0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcount_digit_tx.sv
// Self-checking bench for pcount_digit_tx: directed vector table, multi-cycle corner
// sequences (back-to-back, ignored start, mid-frame reset) and a full input sweep.
// A small receiver model (c1..c3 shift chain) mimics the downstream digit registers.
module tb_pcount_digit_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] count;
    logic       ready;
    logic [3:0] q_out;
    logic       iden;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int qz_err = 0;

    int dig_q[$];
    int dcyc_q[$];
    int done_q[$];
    logic [3:0] c1, c2, c3;

    typedef struct {
        logic [9:0]  cnt;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[12];

    pcount_digit_tx #(.CNT_W(10), .NDIG(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .count (count),
        .ready (ready),
        .q_out (q_out),
        .iden  (iden),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model and strobe recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (iden) begin
                dig_q.push_back(int'(q_out));
                dcyc_q.push_back(cyc);
                c1 <= c2;
                c2 <= c3;
                c3 <= q_out;
            end else if (q_out != 4'h0) begin
                qz_err <= qz_err + 1;
            end
            if (done) done_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        int s;
        s = (v > 999) ? 999 : v;
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic clear_rec();
        dig_q.delete();
        dcyc_q.delete();
        done_q.delete();
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " ready"}, int'(ready), 1);
    endtask

    // One complete frame with nominal timing checks, called from a negedge.
    task automatic run_frame(input logic [9:0] c, input logic [11:0] exp, input string nm);
        int e0;
        wait_ready(nm);
        clear_rec();
        count = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk({nm, " n_iden"}, dig_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < dig_q.size()) begin
                chk($sformatf("%s digit%0d", nm, i), dig_q[i], int'(exp[11-4*i -: 4]));
                chk($sformatf("%s dcyc%0d", nm, i), dcyc_q[i] - e0, 11 + i);
            end
        end
        chk({nm, " n_done"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({nm, " done_cyc"}, done_q[0] - e0, 14);
        chk({nm, " c123"}, int'({c1, c2, c3}), int'(exp));
    endtask

    initial begin
        int e0;
        vecs[0]  = '{10'd725,  12'h725};
        vecs[1]  = '{10'd0,    12'h000};
        vecs[2]  = '{10'd999,  12'h999};
        vecs[3]  = '{10'd1023, 12'h999};
        vecs[4]  = '{10'd1000, 12'h999};
        vecs[5]  = '{10'd100,  12'h100};
        vecs[6]  = '{10'd1,    12'h001};
        vecs[7]  = '{10'd10,   12'h010};
        vecs[8]  = '{10'd509,  12'h509};
        vecs[9]  = '{10'd990,  12'h990};
        vecs[10] = '{10'd123,  12'h123};
        vecs[11] = '{10'd998,  12'h998};

        rst = 1'b0;
        start = 1'b0;
        count = '0;
        c1 = 4'h0; c2 = 4'h0; c3 = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset ready", int'(ready), 1);
        chk("reset iden", int'(iden), 0);
        chk("reset q_out", int'(q_out), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_frame(vecs[i].cnt, vecs[i].exp, $sformatf("vec%0d", i));
            $display("vec%0d count=%0d digits=%0h", i, vecs[i].cnt, {c1, c2, c3});
        end

        // Back-to-back frames with start held high; second accepted in DONE.
        wait_ready("b2b");
        clear_rec();
        count = 10'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        count = 10'd999;
        repeat (14) @(posedge clk);
        #1;
        chk("b2b done_cycle ready", int'(ready), 1);
        chk("b2b done_cycle done", int'(done), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(negedge clk);
        chk("b2b n_iden", dig_q.size(), 6);
        for (int i = 0; i < 6 && i < dig_q.size(); i++) begin
            chk($sformatf("b2b digit%0d", i), dig_q[i], (i < 3) ? 0 : 9);
            chk($sformatf("b2b dcyc%0d", i), dcyc_q[i] - e0, (i < 3) ? 11 + i : 23 + i);
        end
        chk("b2b n_done", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b done0", done_q[0] - e0, 14);
            chk("b2b done1", done_q[1] - e0, 29);
        end
        chk("b2b c123", int'({c1, c2, c3}), 'h999);
        $display("b2b frames digits=%0d", dig_q.size());

        // Start pulses during a busy frame are dropped; late count change ignored.
        wait_ready("ign");
        clear_rec();
        count = 10'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        count = 10'd999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (24) @(negedge clk);
        chk("ign n_iden", dig_q.size(), 3);
        for (int i = 0; i < 3 && i < dig_q.size(); i++) begin
            chk($sformatf("ign digit%0d", i), dig_q[i], (i == 0) ? 0 : ((i == 1) ? 4 : 2));
        end
        chk("ign n_done", done_q.size(), 1);
        $display("ign frame digits=%0d dones=%0d", dig_q.size(), done_q.size());

        // Asynchronous reset during the second digit strobe of count=381.
        wait_ready("rst");
        clear_rec();
        count = 10'd381;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst pre iden", int'(iden), 1);
        chk("rst pre q_out", int'(q_out), 8);
        #1;
        rst = 1'b0;
        #1;
        chk("rst async iden", int'(iden), 0);
        chk("rst async q_out", int'(q_out), 0);
        chk("rst async done", int'(done), 0);
        chk("rst async ready", int'(ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst n_iden", dig_q.size(), 1);
        if (dig_q.size() > 0) chk("rst digit0", dig_q[0], 3);
        chk("rst n_done", done_q.size(), 0);
        $display("rst abandoned frame digits=%0d", dig_q.size());
        run_frame(10'd57, 12'h057, "post_rst");
        $display("post_rst count=57 digits=%0h", {c1, c2, c3});

        // Full input sweep against an arithmetic decimal model.
        for (int v = 0; v < 1024; v++) begin
            run_frame(10'(v), to_bcd(v), $sformatf("sweep%0d", v));
        end
        $display("sweep 0..1023 frames done");

        chk("q_out zero when idle", qz_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
